mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and arbiter for the single shared memory port. It serialises instruction-fetch requests from the PC path and load/store requests from the memory-control path onto one memory interface. It owns the request/acknowledge handshake, the bounded data-over-fetch priority, and the timeout abort. It sits between memory control / PC access and the memory array, and replaces direct driving of the address and data buses by those blocks.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_DATA_RUN, 4, max consecutive data grants while a fetch is pending (≥1)
- TIMEOUT, 15, XFER cycles allowed without mem_rdy before abort (≥1, counter width $clog2(TIMEOUT+1))

Ports:
- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  AW  fetch address (PC zero-extended)
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  DW  fetch data, valid while if_ack=1
- d_req  in  1  data request; held with d_rw/d_addr/d_wdata until d_ack
- d_rw  in  1  1 = read (LDR), 0 = write (STR)
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DW  load data, valid while d_ack=1 and d_rw was 1
- err  out  1  valid with ack: transaction aborted by timeout
- mem_en  out  1  memory access active
- mem_rw  out  1  1 = read, 0 = write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, sampled when mem_rdy=1
- mem_rdy  in  1  memory completes current access this cycle
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, XFER, RESP.
- IDLE, no requests: stay. Otherwise grant per the priority rule below. Latch owner, rw, addr, and wdata into registers, clear the timeout counter, and go to XFER.
- Fetch is always a read.
- Priority: data wins when both are requesting, unless run_cnt == MAX_DATA_RUN. In that case fetch wins.
- run_cnt increments on a data grant while if_req=1. It clears on any fetch grant, and on a data grant while if_req=0.
- XFER: mem_en=1, and mem_rw/mem_addr/mem_wdata come from the latched registers and are stable for the whole state. The memory request inputs are ignored.
  - mem_rdy=1: capture mem_rdata (zero if write), go to RESP with err=0.
  - Else, if tmo_cnt == TIMEOUT-1: go to RESP with err=1 and rdata=0.
  - Else: tmo_cnt+1.
- RESP: assert the owner's ack for exactly one cycle, plus err. Return to IDLE. Requests are not sampled in RESP, so a requester drops or replaces its req in this cycle.
- Reset: state=IDLE, all outputs 0, run_cnt=0, tmo_cnt=0. A transaction in flight is dropped with no ack.
- mem_rdy outside XFER is ignored.
- Request inputs changing during XFER/RESP have no effect.

## Timing
- All outputs are registered or decoded from state and registers only. There is no combinational path from any input to any output.
- Request seen in IDLE at cycle 0:
  - mem_en=1 from cycle 1.
  - If mem_rdy=1 in cycle k (k≥1): ack in cycle k+1, IDLE in cycle k+2.
  - Minimum service: ack 2 cycles after request. Back-to-back period is 3 cycles.
- Timeout: with mem_rdy never asserted, mem_en is high for cycles 1..TIMEOUT. ack+err come in cycle TIMEOUT+1.
- mem_rdy in the same cycle as tmo_cnt == TIMEOUT-1: completion wins, err=0.
- Simultaneous if_req and d_req arriving in the same IDLE cycle: the priority rule applies. No request is ever lost; the loser is served within MAX_DATA_RUN+1 grants.

## Test plan
- Single load:
  - Stimulus: d_req=1, d_rw=1, d_addr=0x40; mem_rdy=1 in cycle 2 with mem_rdata=0xDEADBEEF.
  - Response: mem_en in cycles 1–2, mem_rw=1, mem_addr=0x40. d_ack=1 and d_rdata=0xDEADBEEF in cycle 3, err=0, if_ack=0.
- Single store:
  - Stimulus: d_rw=0, d_addr=0x10, d_wdata=0x12345678; mem_rdy=1 in cycle 1.
  - Response: mem_rw=0, mem_wdata=0x12345678, d_ack in cycle 2, d_rdata=0.
- Starvation bound:
  - Stimulus: if_req and d_req held high continuously, mem_rdy=1 always, MAX_DATA_RUN=4.
  - Response: grant order D,D,D,D,F,D,D,D,D,F…. Each ack is spaced 3 cycles apart.
- Timeout:
  - Stimulus: fetch if_addr=0x08, mem_rdy held 0, TIMEOUT=15.
  - Response: mem_en high in cycles 1–15. if_ack=1, err=1, if_rdata=0 in cycle 16. IDLE in cycle 17.
- Race at the limit:
  - Stimulus: mem_rdy=1 exactly in cycle 15 (TIMEOUT=15).
  - Response: ack in cycle 16 with err=0 and captured data.
- Reset mid-transfer:
  - Stimulus: Reset=1 in cycle 3 of an XFER.
  - Response: cycle 4 has mem_en=0, busy=0, no ack ever for that request. A new d_req after reset is served normally with run_cnt=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared memory port bundle: fetch and data requesters on one side,
// the memory array on the other, with the arbiter sitting in between.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_rw;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_en;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;
  logic          busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_rw, d_addr, d_wdata,
    input  mem_rdata, mem_rdy,
    output if_ack, if_rdata,
    output d_ack, d_rdata, err,
    output mem_en, mem_rw, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_rw, d_addr, d_wdata,
    output mem_rdata, mem_rdy,
    input  if_ack, if_rdata,
    input  d_ack, d_rdata, err,
    input  mem_en, mem_rw, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store requests onto the single memory port,
// with bounded data-over-fetch priority and a per-access timeout abort.
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 15
) (
  input logic         Clk,
  input logic         Reset,
  mem_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_DATA_RUN + 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          own_d;
  logic          rw_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] run_cnt;

  logic any_req;
  logic run_full;
  logic grant_d;
  logic grant_f;
  logic tmo_hit;
  logic in_xfer;
  logic in_resp;

  always_comb begin
    any_req  = bus.if_req | bus.d_req;
    run_full = run_cnt == RW'(MAX_DATA_RUN);
    grant_d  = bus.d_req & ~(bus.if_req & run_full);
    grant_f  = bus.if_req & ~grant_d;
    tmo_hit  = tmo_cnt == TW'(TIMEOUT - 1);
    state_n  = state;
    unique case (state)
      IDLE:    if (any_req) state_n = XFER;
      XFER:    if (bus.mem_rdy | tmo_hit) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Transaction registers; bus outputs come only from these and state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      own_d   <= 1'b0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tmo_cnt <= '0;
      run_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            own_d   <= grant_d;
            rw_q    <= grant_d ? bus.d_rw : 1'b1;
            addr_q  <= grant_f ? bus.if_addr : bus.d_addr;
            wdata_q <= grant_d ? bus.d_wdata : '0;
            tmo_cnt <= '0;
            run_cnt <= (grant_d & bus.if_req) ? run_cnt + 1'b1 : '0;
          end
        end
        XFER: begin
          if (bus.mem_rdy) begin
            rdata_q <= rw_q ? bus.mem_rdata : '0;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_xfer = state == XFER;
  assign in_resp = state == RESP;

  assign bus.busy      = state != IDLE;
  assign bus.mem_en    = in_xfer;
  assign bus.mem_rw    = in_xfer & rw_q;
  assign bus.mem_addr  = in_xfer ? addr_q : '0;
  assign bus.mem_wdata = in_xfer ? wdata_q : '0;
  assign bus.if_ack    = in_resp & ~own_d;
  assign bus.d_ack     = in_resp & own_d;
  assign bus.if_rdata  = (in_resp & ~own_d) ? rdata_q : '0;
  assign bus.d_rdata   = (in_resp & own_d) ? rdata_q : '0;
  assign bus.err       = in_resp & err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model feeds a scoreboard,
// random and directed requesters plus a random-latency memory.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXR = 4;
  localparam int TMO  = 15;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(
    .AW(AW),
    .DW(DW),
    .MAX_DATA_RUN(MAXR),
    .TIMEOUT(TMO)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  typedef struct {
    bit            is_d;
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    bit            is_d;
    logic [DW-1:0] rdata;
    bit            err;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_dack = 0;
  int n_iack = 0;
  int n_err = 0;

  int d_pct = 0;
  int f_pct = 0;
  int rdy_pct = 100;
  int rdy_at = 0;
  bit fix_en = 1'b0;
  logic [DW-1:0] fix_val = '0;
  int d_seq = 0;
  int f_seq = 0;
  int d_done = 0;
  int f_done = 0;
  logic          d_cmd_rw = 1'b0;
  logic [AW-1:0] d_cmd_addr = '0;
  logic [DW-1:0] d_cmd_wdata = '0;
  logic [AW-1:0] f_cmd_addr = '0;
  int xc = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Requesters: hold until ack, then drop or replace within the ack cycle.
  initial begin
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_req = 1'b0;
    bus.d_rw = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    forever begin
      @(posedge Clk);
      #2;
      if (Reset) begin
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
      end else begin
        if (bus.d_ack) bus.d_req = 1'b0;
        if (bus.if_ack) bus.if_req = 1'b0;
        if (!bus.d_req) begin
          if (d_seq != d_done) begin
            d_done = d_seq;
            bus.d_req = 1'b1;
            bus.d_rw = d_cmd_rw;
            bus.d_addr = d_cmd_addr;
            bus.d_wdata = d_cmd_wdata;
          end else if ($urandom_range(99) < d_pct) begin
            bus.d_req = 1'b1;
            bus.d_rw = 1'($urandom_range(1));
            bus.d_addr = $urandom;
            bus.d_wdata = $urandom;
          end
        end
        if (!bus.if_req) begin
          if (f_seq != f_done) begin
            f_done = f_seq;
            bus.if_req = 1'b1;
            bus.if_addr = f_cmd_addr;
          end else if ($urandom_range(99) < f_pct) begin
            bus.if_req = 1'b1;
            bus.if_addr = $urandom & 32'hFFFF_FFFC;
          end
        end
      end
    end
  end

  // Memory: fixed-latency or random ready, ready also toggles while idle.
  initial begin
    bus.mem_rdy = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge Clk);
      #2;
      xc = bus.mem_en ? xc + 1 : 0;
      if (rdy_at != 0) bus.mem_rdy = bus.mem_en && (xc == rdy_at);
      else bus.mem_rdy = $urandom_range(99) < rdy_pct;
      bus.mem_rdata = fix_en ? fix_val : $urandom;
    end
  end

  // Reference model: m_st 0 = free, 1 = accessing, 2 = responding.
  int   m_st = 0;
  int   m_cnt = 0;
  int   m_run = 0;
  bit   m_dwin;
  req_t m_cur;
  rsp_t m_rsp;

  always @(negedge Clk) begin
    if (!Reset) begin
      chk("busy", bus.busy, m_st != 0);
      chk("mem_en", bus.mem_en, m_st == 1);
    end
    if (Reset) begin
      m_st = 0;
      m_run = 0;
      req_q.delete();
      rsp_q.delete();
    end else begin
      case (m_st)
        0: if (bus.if_req || bus.d_req) begin
          m_dwin = bus.d_req && !(bus.if_req && m_run == MAXR);
          m_run = (m_dwin && bus.if_req) ? m_run + 1 : 0;
          m_cur.is_d = m_dwin;
          m_cur.rw = m_dwin ? bus.d_rw : 1'b1;
          m_cur.addr = m_dwin ? bus.d_addr : bus.if_addr;
          m_cur.wdata = bus.d_wdata;
          req_q.push_back(m_cur);
          m_cnt = 0;
          m_st = 1;
        end
        1: begin
          m_cnt++;
          if (bus.mem_rdy || m_cnt == TMO) begin
            m_rsp.is_d = m_cur.is_d;
            m_rsp.err = !bus.mem_rdy;
            m_rsp.rdata = (bus.mem_rdy && m_cur.rw) ? bus.mem_rdata : '0;
            rsp_q.push_back(m_rsp);
            m_st = 2;
          end
        end
        default: m_st = 0;
      endcase
    end
  end

  // Monitor / scoreboard.
  rsp_t  s_rsp;
  req_t  s_req;
  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.mem_en) begin
        if (req_q.size() == 0) fail("mem_en_unexpected");
        else begin
          chk("mem_addr", bus.mem_addr, req_q[0].addr);
          chk("mem_rw", bus.mem_rw, req_q[0].rw);
          if (!req_q[0].rw) chk("mem_wdata", bus.mem_wdata, req_q[0].wdata);
        end
      end
      if (bus.if_ack || bus.d_ack) begin
        if (rsp_q.size() == 0 || req_q.size() == 0) fail("ack_unexpected");
        else begin
          s_rsp = rsp_q.pop_front();
          s_req = req_q.pop_front();
          chk("ack_owner", bus.d_ack, s_rsp.is_d);
          chk("ack_both", bus.d_ack & bus.if_ack, 0);
          chk("rdata", s_rsp.is_d ? bus.d_rdata : bus.if_rdata, s_rsp.rdata);
          chk("err", bus.err, s_rsp.err);
          if (bus.d_ack) n_dack++;
          if (bus.if_ack) n_iack++;
          if (bus.err) n_err++;
        end
      end
    end
  end

  task automatic run(int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  int b_d, b_i, b_e, k;

  initial begin
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_acks", {bus.if_ack, bus.d_ack, bus.err}, 0);
    chk("rst_bus", {bus.mem_rw, bus.mem_addr, bus.mem_wdata}, 0);
    chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
    #1;

    // single load, ready in the second access cycle
    fix_en = 1'b1;
    fix_val = 32'hDEAD_BEEF;
    rdy_at = 2;
    d_cmd_rw = 1'b1;
    d_cmd_addr = 32'h40;
    d_cmd_wdata = 32'h0;
    b_d = n_dack;
    d_seq++;
    run(8);
    chk("load_acks", n_dack - b_d, 1);

    // single store, ready at once
    rdy_at = 1;
    d_cmd_rw = 1'b0;
    d_cmd_addr = 32'h10;
    d_cmd_wdata = 32'h1234_5678;
    b_d = n_dack;
    d_seq++;
    run(8);
    chk("store_acks", n_dack - b_d, 1);

    // fetch that never completes
    rdy_at = 0;
    rdy_pct = 0;
    f_cmd_addr = 32'h08;
    b_i = n_iack;
    b_e = n_err;
    f_seq++;
    run(TMO + 6);
    chk("tmo_acks", n_iack - b_i, 1);
    chk("tmo_errs", n_err - b_e, 1);

    // ready on the last allowed cycle
    rdy_at = TMO;
    fix_val = 32'hCAFE_F00D;
    f_cmd_addr = 32'h0C;
    b_i = n_iack;
    b_e = n_err;
    f_seq++;
    run(TMO + 6);
    chk("race_acks", n_iack - b_i, 1);
    chk("race_errs", n_err - b_e, 0);

    // both requesters saturating
    rdy_at = 0;
    rdy_pct = 100;
    fix_en = 1'b0;
    b_d = n_dack;
    b_i = n_iack;
    d_pct = 100;
    f_pct = 100;
    run(75);
    d_pct = 0;
    f_pct = 0;
    run(6);
    chk("starve_fetches", (n_iack - b_i) > 3, 1);
    chk("starve_data", (n_dack - b_d) > 15, 1);

    // reset during the third access cycle
    rdy_pct = 0;
    d_cmd_rw = 1'b1;
    d_cmd_addr = 32'h80;
    d_seq++;
    k = 0;
    while (!bus.mem_en && k < 20) begin
      @(negedge Clk);
      k++;
    end
    chk("rst_xfer_seen", bus.mem_en, 1);
    b_d = n_dack;
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_mid_mem_en", bus.mem_en, 0);
    chk("rst_mid_busy", bus.busy, 0);
    #1;
    rdy_pct = 100;
    d_cmd_addr = 32'h84;
    d_seq++;
    run(10);
    chk("post_rst_acks", n_dack - b_d, 1);

    // random traffic at mixed memory latencies
    d_pct = 40;
    f_pct = 40;
    for (int i = 0; i < 6; i++) begin
      rdy_pct = (i % 3 == 0) ? 3 : ((i % 3 == 1) ? 50 : 100);
      run(400);
    end
    d_pct = 0;
    f_pct = 0;
    rdy_pct = 100;
    k = 0;
    while ((bus.busy || bus.if_req || bus.d_req) && k < 100) begin
      @(negedge Clk);
      k++;
    end
    if (k >= 100) fail("drain_timeout");
    run(2);
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("req_q_empty", req_q.size(), 0);
    chk("saw_timeouts", n_err > 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
